// File: rtl/regfile.sv
// 32-entry x WIDTH register file: one write port, two combinational read ports, one hard-wired zero.
// Optional write-through forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile #(
    parameter int unsigned WIDTH    = 64,
    parameter int unsigned ZERO_REG = 31
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             RegWrite,
    input  logic [4:0]       WriteRegister,
    input  logic [WIDTH-1:0] WriteData,
    input  logic [4:0]       ReadRegister1,
    input  logic [4:0]       ReadRegister2,
    output logic [WIDTH-1:0] ReadData1,
    output logic [WIDTH-1:0] ReadData2
);

    localparam logic [4:0] ZeroIdx = 5'(ZERO_REG);

    logic [31:0]      w_wr_en;
    logic [WIDTH-1:0] w_leaf [32];
    logic [WIDTH-1:0] w_mux1;
    logic [WIDTH-1:0] w_mux2;

    // 5:32 one-hot write decode; the zero register's enable is forced off
    always_comb begin
        w_wr_en = '0;
        if (RegWrite) begin
            w_wr_en[WriteRegister] = 1'b1;
        end
        w_wr_en[ZeroIdx] = 1'b0;
    end

    for (genvar i = 0; i < 32; i++) begin : g_reg
        if (i == int'(ZERO_REG)) begin : g_zero
            assign w_leaf[i] = '0;
        end else begin : g_store
            logic [WIDTH-1:0] r_data;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_data <= '0;
                end else if (w_wr_en[i]) begin
                    r_data <= WriteData;
                end
            end

            assign w_leaf[i] = r_data;
        end
    end

    // Binary 32:1 mux tree, select bit 0 resolves the leaf pairs
    function automatic logic [WIDTH-1:0] mux32(input logic [WIDTH-1:0] leaves [32],
                                               input logic [4:0]       sel);
        logic [WIDTH-1:0] node [32];
        node = leaves;
        for (int lvl = 0; lvl < 5; lvl++) begin
            for (int j = 0; j < (16 >> lvl); j++) begin
                node[j] = sel[lvl] ? node[2*j+1] : node[2*j];
            end
        end
        return node[0];
    endfunction

    always_comb begin
        w_mux1 = mux32(w_leaf, ReadRegister1);
        w_mux2 = mux32(w_leaf, ReadRegister2);
    end

`ifdef REGFILE_BYPASS_EN
    logic w_fwd1;
    logic w_fwd2;

    always_comb begin
        w_fwd1 = RegWrite && (WriteRegister != ZeroIdx) && (WriteRegister == ReadRegister1);
        w_fwd2 = RegWrite && (WriteRegister != ZeroIdx) && (WriteRegister == ReadRegister2);
        ReadData1 = '0;
        ReadData2 = '0;
        if (reset_n) begin
            ReadData1 = w_fwd1 ? WriteData : w_mux1;
            ReadData2 = w_fwd2 ? WriteData : w_mux2;
        end
    end
`else
    always_comb begin
        ReadData1 = '0;
        ReadData2 = '0;
        if (reset_n) begin
            ReadData1 = w_mux1;
            ReadData2 = w_mux2;
        end
    end
`endif

endmodule

// File: doc/regfile.md
REGFILE -- requirements
Module: regfile

Interface
REQ-001 Parameter: WIDTH, 64, data bits per register; all data ports SHALL be WIDTH wide.
REQ-002 Parameter: ZERO_REG, 31, index of hard-wired zero register.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-005 Port: RegWrite  input  1  write enable, sampled on rising clk.
REQ-006 Port: WriteRegister  input  5  destination register index.
REQ-007 Port: WriteData  input  WIDTH  data to write.
REQ-008 Port: ReadRegister1  input  5  read port 1 index.
REQ-009 Port: ReadRegister2  input  5  read port 2 index.
REQ-010 Port: ReadData1  output  WIDTH  contents of ReadRegister1.
REQ-011 Port: ReadData2  output  WIDTH  contents of ReadRegister2.

Function
REQ-012 Storage SHALL be 31 WIDTH-bit registers, indices 0-30; index ZERO_REG SHALL have no storage.
REQ-013 Write: on rising clk with RegWrite=1 and WriteRegister!=ZERO_REG, register[WriteRegister] SHALL load WriteData; all other registers SHALL hold.
REQ-014 Write decode SHALL be a 5:32 one-hot decoder gated by RegWrite; at most one register enable SHALL be active per cycle.
REQ-015 RegWrite=0 SHALL leave all registers unchanged regardless of WriteRegister/WriteData.
REQ-016 Write to ZERO_REG SHALL be discarded silently; no other register SHALL be affected.
REQ-017 Read ports SHALL be combinational (zero-cycle latency) through two 64-bit 32:1 mux trees, one per port, selected by ReadRegisterN.
REQ-018 Reads of ZERO_REG SHALL return all-zeros at all times.
REQ-019 Both read ports SHALL operate independently; identical indices SHALL return identical data.
REQ-020 A value written at edge N SHALL be visible on read ports after edge N and hold until the next write to that index.
REQ-021 Same-cycle read/write of one index: behaviour SHALL be per REQ-026/REQ-027.
REQ-022 Outputs SHALL never be X when inputs are known and reset has been applied once.

Reset
REQ-023 reset_n=0 SHALL clear all 31 registers to 0 immediately, independent of clk.
REQ-024 While reset_n=0, writes SHALL be blocked and ReadData1/ReadData2 SHALL be 0 for every index.
REQ-025 Reset asserted in the same cycle as a write SHALL win; the register SHALL read 0 after reset deasserts.

Configuration
REQ-026 Macro REGFILE_BYPASS_EN defined: when RegWrite=1, WriteRegister==ReadRegisterN and WriteRegister!=ZERO_REG, ReadDataN SHALL equal WriteData combinationally in that same cycle (write-through forwarding; reset_n=0 overrides to 0).
REQ-027 Macro REGFILE_BYPASS_EN undefined: ReadDataN SHALL return the stored (pre-edge) value during the write cycle and the new value only after the rising edge.

Verification
REQ-028 Reset: reset_n=0 mid-cycle after loading X5=0xDEAD -> ReadData1 with ReadRegister1=5 goes 0 without a clk edge; stays 0 after deassert.
REQ-029 Fill/readback: write Xi=0x1111_0000_0000_0000+i for i=0..30, then read all pairs (i, 30-i) -> both ports return exact values; no cross-writes.
REQ-030 Zero register: RegWrite=1, WriteRegister=31, WriteData=0xFFFF_FFFF_FFFF_FFFF -> ReadData1/2 at index 31 = 0; X0..X30 unchanged.
REQ-031 Write disable: RegWrite=0, WriteRegister=7, WriteData=0x1234 across 3 edges -> X7 retains prior value 0xABCD.
REQ-032 Same-cycle hazard: X9=0x1, RegWrite=1, WriteRegister=9, WriteData=0x2, ReadRegister1=9 -> before edge ReadData1=0x2 with REGFILE_BYPASS_EN, 0x1 without; after edge 0x2 in both builds.
REQ-033 Dual-port same index: ReadRegister1=ReadRegister2=12 after writing 0x5A5A -> both outputs 0x5A5A in the same cycle.
